// File: rtl/pce_clk_pkg.sv
// Shared types and constants for the PC Engine clock-enable / core-reset generator.
package pce_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2
  } pce_state_e;

  localparam int unsigned SYS_CLK_HZ   = 42_954_541;

  localparam int unsigned CPU_DIV_FAST = 6;
  localparam int unsigned CPU_DIV_SLOW = 24;
  localparam int unsigned PSG_DIV      = 12;
  localparam int unsigned VDC_DIV [4]  = '{8, 6, 4, 4};

  localparam int LOCK_CNT_W = 16;
  localparam int CPU_CNT_W  = 5;
  localparam int VDC_CNT_W  = 4;
  localparam int PSG_CNT_W  = 4;

  function automatic logic [CPU_CNT_W-1:0] cpu_div(input logic fast);
    return fast ? CPU_CNT_W'(CPU_DIV_FAST) : CPU_CNT_W'(CPU_DIV_SLOW);
  endfunction

  function automatic logic [VDC_CNT_W-1:0] vdc_div(input logic [1:0] mode);
    return VDC_CNT_W'(VDC_DIV[mode]);
  endfunction

endpackage

// File: rtl/pce_ce_div.sv
// Wrapping divide-by-N counter producing a registered one-cycle enable strobe.
// The divisor is sampled only at start and on wrap so a period is never cut short.
module pce_ce_div
  import pce_clk_pkg::*;
#(
  parameter int          CNT_W   = 4,
  parameter int unsigned DIV_RST = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             run_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             ce_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             ce_q, ce_d;
  logic [CNT_W-1:0] last;
  logic             wrap;

  assign last = div_q - ONE;
  assign wrap = (cnt_q >= last);

  always_comb begin
    cnt_d = '0;
    div_d = div_q;
    if (start_i) begin
      div_d = div_i;
    end else if (run_i) begin
      cnt_d = wrap ? '0 : cnt_q + ONE;
      if (wrap) div_d = div_i;
    end
    // Strobe is registered so it lines up with the cycle the counter sits at DIV-1.
    ce_d = run_i && (cnt_d == last);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      div_q <= CNT_W'(DIV_RST);
      ce_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
      ce_q  <= ce_d;
    end
  end

  assign ce_o = ce_q;

endmodule

// File: rtl/pce_clk_reset_gen.sv
// Qualifies PLL lock, holds the PC Engine core in reset until lock is stable,
// then generates the CPU / VDC / PSG clock-enable strobes.
module pce_clk_reset_gen
  import pce_clk_pkg::*;
#(
  parameter int unsigned LOCK_CYCLES = 4096
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       cpu_fast,
  input  logic [1:0] dot_mode,
  output logic       core_reset_n,
  output logic       ce_cpu,
  output logic       ce_vdc,
  output logic       ce_psg,
  output logic [7:0] lock_loss_count
);

  localparam logic [LOCK_CNT_W-1:0] LOCK_LAST = LOCK_CNT_W'(LOCK_CYCLES - 1);
  localparam logic [LOCK_CNT_W-1:0] LOCK_ONE  = LOCK_CNT_W'(1);

  logic                  sync1_q, lk_s_q;
  pce_state_e            state_q, state_d;
  logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [7:0]            loss_q, loss_d;
  logic                  core_rst_n_q;
  logic                  div_start, div_run;

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    loss_d     = loss_q;
    case (state_q)
      WAIT_LOCK: begin
        lock_cnt_d = '0;
        if (lk_s_q) state_d = STABLE;
      end
      STABLE: begin
        if (!lk_s_q) begin
          state_d    = WAIT_LOCK;
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LOCK_LAST) begin
          state_d    = RUN;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + LOCK_ONE;
        end
      end
      RUN: begin
        if (!lk_s_q) begin
          state_d = WAIT_LOCK;
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= 1'b0;
      lk_s_q       <= 1'b0;
      state_q      <= WAIT_LOCK;
      lock_cnt_q   <= '0;
      loss_q       <= 8'd0;
      core_rst_n_q <= 1'b0;
    end else begin
      sync1_q      <= pll_locked;
      lk_s_q       <= sync1_q;
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      loss_q       <= loss_d;
      core_rst_n_q <= (state_d == RUN);
    end
  end

  // Dividers run only while RUN is both current and next, so strobes drop
  // on the same edge that core_reset_n falls.
  assign div_start = (state_d == RUN) && (state_q != RUN);
  assign div_run   = (state_d == RUN) && (state_q == RUN);

  pce_ce_div #(.CNT_W(CPU_CNT_W), .DIV_RST(CPU_DIV_SLOW)) u_cpu_div (
    .clk_i   (clk_sys),
    .rst_ni  (reset_n),
    .start_i (div_start),
    .run_i   (div_run),
    .div_i   (cpu_div(cpu_fast)),
    .ce_o    (ce_cpu)
  );

  pce_ce_div #(.CNT_W(VDC_CNT_W), .DIV_RST(VDC_DIV[0])) u_vdc_div (
    .clk_i   (clk_sys),
    .rst_ni  (reset_n),
    .start_i (div_start),
    .run_i   (div_run),
    .div_i   (vdc_div(dot_mode)),
    .ce_o    (ce_vdc)
  );

  pce_ce_div #(.CNT_W(PSG_CNT_W), .DIV_RST(PSG_DIV)) u_psg_div (
    .clk_i   (clk_sys),
    .rst_ni  (reset_n),
    .start_i (div_start),
    .run_i   (div_run),
    .div_i   (PSG_CNT_W'(PSG_DIV)),
    .ce_o    (ce_psg)
  );

  assign core_reset_n    = core_rst_n_q;
  assign lock_loss_count = loss_q;

endmodule
